// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU: request handshake, operands,
// flush, and the registered result handshake.
interface alu_mc_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result, zero
    );

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle RV32I-style ops plus iterative shift-add multiply
// and restoring divide on magnitudes, with a fixed XLEN+2 latency for the latter.
module alu_mc #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q;
    logic                b_zero_q;
    logic                neg_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   x_q;
    logic [XLEN-1:0]     y_q;
    logic [CW-1:0]       cnt_q;
    logic [XLEN-1:0]     result_q;
    logic                zero_q;

    logic                accept;
    logic                iter_op;
    logic                last_step;
    logic [SHW-1:0]      sh;
    logic [XLEN-1:0]     alu_res;
    logic                sa, sb, a_neg, b_neg;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic [2*XLEN:0]     div_sh;
    logic                div_ge;
    logic [XLEN-1:0]     div_diff;
    logic [2*XLEN-1:0]   step_acc;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     qr;
    logic [XLEN-1:0]     fix;

    assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready && !bus.flush;
    assign iter_op       = (bus.op[4:3] == 2'b10);
    assign last_step     = (cnt_q == CW'(XLEN));
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = iter_op ? BUSY : DONE;
                BUSY: if (last_step) state_d = DONE;
                DONE: begin
                    if (accept)             state_d = iter_op ? BUSY : DONE;
                    else if (bus.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sh      = bus.b[SHW-1:0];
        alu_res = '0;
        case (bus.op)
            5'h00: alu_res = bus.a + bus.b;
            5'h01: alu_res = bus.a - bus.b;
            5'h02: alu_res = bus.a << sh;
            5'h03: alu_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            5'h04: alu_res = bus.a ^ bus.b;
            5'h05: alu_res = bus.a >> sh;
            5'h06: alu_res = bus.a | bus.b;
            5'h07: alu_res = bus.a & bus.b;
            5'h08: alu_res = $unsigned($signed(bus.a) >>> sh);
            5'h09: alu_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
            default: alu_res = '0;
        endcase
    end

    // Magnitudes are taken at accept time, so the accept edge doubles as the setup step.
    always_comb begin
        sa    = (bus.op == 5'h11) || (bus.op == 5'h12) || (bus.op == 5'h14) || (bus.op == 5'h16);
        sb    = (bus.op == 5'h11) || (bus.op == 5'h14) || (bus.op == 5'h16);
        a_neg = sa && bus.a[XLEN-1];
        b_neg = sb && bus.b[XLEN-1];
        abs_a = a_neg ? (~bus.a + 1'b1) : bus.a;
        abs_b = b_neg ? (~bus.b + 1'b1) : bus.b;
    end

    always_comb begin
        div_sh   = {acc_q, 1'b0};
        div_ge   = div_sh[2*XLEN:XLEN] >= {1'b0, x_q[XLEN-1:0]};
        div_diff = div_sh[2*XLEN-1:XLEN] - x_q[XLEN-1:0];
        if (op_q[2]) begin
            step_acc = div_ge ? {div_diff, div_sh[XLEN-1:1], 1'b1} : div_sh[2*XLEN-1:0];
        end else begin
            step_acc = y_q[0] ? (acc_q + x_q) : acc_q;
        end
        prod = neg_q ? (~acc_q + 1'b1) : acc_q;
        qr   = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (!op_q[2])     fix = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (b_zero_q) fix = op_q[1] ? a_q : '1;
        else               fix = neg_q ? (~qr + 1'b1) : qr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_zero_q <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (bus.flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            op_q     <= bus.op[2:0];
            a_q      <= bus.a;
            b_zero_q <= (bus.b == '0);
            cnt_q    <= '0;
            if (iter_op && bus.op[2]) begin
                acc_q <= {{XLEN{1'b0}}, abs_a};
                x_q   <= {{XLEN{1'b0}}, abs_b};
                y_q   <= '0;
                neg_q <= bus.op[1] ? a_neg : (a_neg ^ b_neg);
            end else if (iter_op) begin
                acc_q <= '0;
                x_q   <= {{XLEN{1'b0}}, abs_a};
                y_q   <= abs_b;
                neg_q <= a_neg ^ b_neg;
            end else begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
            end
        end else if (state_q == BUSY) begin
            if (last_step) begin
                result_q <= fix;
                zero_q   <= (fix == '0);
            end else begin
                acc_q <= step_acc;
                if (!op_q[2]) x_q <= {x_q[2*XLEN-2:0], 1'b0};
                y_q   <= y_q >> 1;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL derive localparam SHW = log2(XLEN), the shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port op  input  5  operation selector.
REQ-008 SHALL have port a  input  XLEN  first operand.
REQ-009 SHALL have port b  input  XLEN  second operand.
REQ-010 SHALL have port flush  input  1  synchronous abort of any in-flight or held operation.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  XLEN  registered result.
REQ-014 SHALL have port zero  output  1  registered flag, high iff result == 0.

Function
REQ-015 SHALL accept a request on a rising edge where in_valid && in_ready && !flush, capturing op, a and b.
REQ-016 SHALL support single-cycle ops: 00 add, 01 sub, 02 sll, 03 slt, 04 xor, 05 srl, 06 or, 07 and, 08 sra, 09 sltu; shifts use b[SHW-1:0] only; slt/sltu yield 1 or 0.
REQ-017 SHALL support iterative ops: 10 mul, 11 mulh, 12 mulhsu, 13 mulhu, 14 div, 15 divu, 16 rem, 17 remu (hex), with RISC-V M semantics at width XLEN.
REQ-018 SHALL implement unlisted op codes as single-cycle ops with result 0.
REQ-019 SHALL use FSM states IDLE, BUSY, DONE.
  - IDLE -> DONE on accept of a single-cycle op.
  - IDLE -> BUSY on accept of an iterative op.
  - BUSY -> DONE when the iteration counter expires.
  - DONE -> IDLE on out_ready with no new accept.
  - DONE -> DONE/BUSY on out_ready with a simultaneous new accept.
REQ-020 SHALL drive in_ready = (state == IDLE) || (state == DONE && out_ready), giving back-to-back throughput for single-cycle ops.
REQ-021 SHALL assert out_valid exactly when state == DONE; result and zero SHALL hold stable while out_valid && !out_ready.
REQ-022 SHALL have fixed latency: out_valid rises on edge N+1 after a single-cycle accept at edge N, and on edge N+XLEN+2 after an iterative accept (1 setup, XLEN radix-2 steps, 1 sign fix-up).
REQ-023 SHALL implement multiply as shift-add on absolute values with a 2*XLEN accumulator, negating the product when signs differ; mul returns the low half, mulh/mulhsu/mulhu the high half.
REQ-024 SHALL implement divide as restoring division on absolute values; the quotient sign is sign(a) xor sign(b), and the remainder takes the sign of a.
REQ-025 SHALL handle divide by zero (b == 0) with the full fixed latency: div/divu quotient = all ones, rem/remu = a.
REQ-026 SHALL handle signed overflow (a = most-negative, b = -1): div = a, rem = 0.
REQ-027 SHALL make flush take priority over everything: next state IDLE, out_valid 0, no request accepted that edge, counter cleared, result/zero unchanged.
REQ-028 SHALL leave in_ready low during BUSY and ignore in_valid there.

Reset
REQ-029 SHALL on rst high, immediately and independent of clk, force state IDLE, out_valid 0, result 0, zero 1, counter 0 and all datapath registers 0.
REQ-030 SHALL on rst asserted mid-BUSY or mid-DONE discard the operation; the first accept after rst deassertion SHALL behave as from power-up.

Verification
REQ-031 SHALL pass, at XLEN=32: add a=0xFFFFFFFF b=1 -> out_valid at N+1, result 0, zero 1; sra a=0x80000000 b=0x24 -> 0xF8000000 (shift 4).
REQ-032 SHALL pass: mulh a=0x80000000 b=0x80000000 -> result 0x40000000 at exactly N+34; mulhu a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 SHALL pass: div a=7 b=0 -> 0xFFFFFFFF; rem a=7 b=0 -> 7; div a=0x80000000 b=0xFFFFFFFF -> 0x80000000; rem same operands -> 0; div a=-7 b=2 -> -3, rem -> -1.
REQ-034 SHALL pass: out_ready held low 5 cycles in DONE -> result stable, in_ready 0; then out_ready high with in_valid high -> new op accepted the same edge.
REQ-035 SHALL pass: flush at cycle 10 of a divu -> IDLE next edge, no out_valid; a following add completes normally.
REQ-036 SHALL pass: rst pulse mid-BUSY with clk stopped -> out_valid 0 and zero 1 immediately; at XLEN=8, mul 0x0F*0x11 -> 0xFF at N+10.
